// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared key codes, ALU op encoding, sequencer states and defaults for the calculator.
package calc_pkg;

    localparam int W_DEF         = 16;
    localparam int NDIG_DEF      = 4;
    localparam int TO_CYCLES_DEF = 1024;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_MUL = 4'hC;
    localparam logic [3:0] KEY_DIV = 4'hD;
    localparam logic [3:0] KEY_EQ  = 4'hE;
    localparam logic [3:0] KEY_CLR = 4'hF;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        ENTER_A,
        ENTER_B,
        EXEC,
        WAIT,
        SHOW,
        ERR
    } state_t;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

    function automatic logic is_op(input logic [3:0] k);
        return (k >= KEY_ADD) && (k <= KEY_DIV);
    endfunction

    // A..D map onto 00..11 by subtracting 2 from the low two bits.
    function automatic logic [1:0] key_to_op(input logic [3:0] k);
        return k[1:0] - 2'b10;
    endfunction

endpackage

// File: rtl/calc_dec_acc.sv
// rtl/calc_dec_acc.sv - decimal operand accumulator with clear/load/shift-in-digit and saturating digit count.
module calc_dec_acc
    import calc_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int NDIG = NDIG_DEF,
    parameter int CW   = $clog2(NDIG + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          load_i,
    input  logic [W-1:0]  load_val_i,
    input  logic [CW-1:0] load_cnt_i,
    input  logic          shift_i,
    input  logic [3:0]    digit_i,
    output logic [W-1:0]  acc_o,
    output logic [CW-1:0] cnt_o,
    output logic [W-1:0]  acc_nxt_o,
    output logic [CW-1:0] cnt_nxt_o
);

    logic [W-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (load_i) begin
            acc_d = load_val_i;
            cnt_d = load_cnt_i;
        end else if (shift_i && (cnt_q < CW'(NDIG))) begin
            // Digits past NDIG are swallowed without touching the value.
            acc_d = acc_q * W'(10) + W'(digit_i);
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign acc_o     = acc_q;
    assign cnt_o     = cnt_q;
    assign acc_nxt_o = acc_d;
    assign cnt_nxt_o = cnt_d;

endmodule

// File: rtl/calc_seq_ctrl.sv
// rtl/calc_seq_ctrl.sv - keypad-to-ALU sequencer; CALC_SEQ_CTRL_TIMEOUT_EN adds an ALU watchdog in WAIT.
module calc_seq_ctrl
    import calc_pkg::*;
#(
    parameter int W         = W_DEF,
    parameter int NDIG      = NDIG_DEF,
    parameter int TO_CYCLES = TO_CYCLES_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    input  logic [3:0]   key_code,
    output logic         key_ready,
    output logic         alu_start,
    output logic [1:0]   alu_op,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    input  logic         alu_done,
    input  logic [W-1:0] alu_result,
    input  logic         alu_err,
    output logic [W-1:0] disp_val,
    output logic         disp_err,
    output logic         busy
);

    localparam int CW = $clog2(NDIG + 1);

    state_t         state_q, state_d;
    logic [1:0]     op_q, op_d, pend_q, pend_d, alu_op_q, alu_op_d;
    logic           chain_q, chain_d, disp_err_q, disp_err_d;
    logic [W-1:0]   disp_val_q, disp_val_d, alu_a_q, alu_a_d, alu_b_q, alu_b_d;

    logic           a_clr, a_load, a_shift, b_clr, b_shift;
    logic [W-1:0]   a_load_val, a_acc, a_nxt, b_acc, b_nxt;
    logic [CW-1:0]  a_load_cnt, a_cnt, a_cnt_nxt, b_cnt, b_cnt_nxt;
    logic           key_acc, to_hit, unused_a_cnt;

    calc_dec_acc #(.W(W), .NDIG(NDIG), .CW(CW)) u_acc_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (a_clr),
        .load_i     (a_load),
        .load_val_i (a_load_val),
        .load_cnt_i (a_load_cnt),
        .shift_i    (a_shift),
        .digit_i    (key_code),
        .acc_o      (a_acc),
        .cnt_o      (a_cnt),
        .acc_nxt_o  (a_nxt),
        .cnt_nxt_o  (a_cnt_nxt)
    );

    calc_dec_acc #(.W(W), .NDIG(NDIG), .CW(CW)) u_acc_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (b_clr),
        .load_i     (1'b0),
        .load_val_i ('0),
        .load_cnt_i ('0),
        .shift_i    (b_shift),
        .digit_i    (key_code),
        .acc_o      (b_acc),
        .cnt_o      (b_cnt),
        .acc_nxt_o  (b_nxt),
        .cnt_nxt_o  (b_cnt_nxt)
    );

    assign unused_a_cnt = ^{a_cnt, a_cnt_nxt};

`ifdef CALC_SEQ_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYCLES + 1);
    logic [TW-1:0] to_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n || (state_q != WAIT)) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + TW'(1);
        end
    end

    assign to_hit = (to_cnt_q == TW'(TO_CYCLES - 1));
`else
    assign to_hit = (TO_CYCLES < 0);
`endif

    assign busy      = (state_q == EXEC) || (state_q == WAIT);
    assign key_ready = !busy;
    assign key_acc   = key_valid && key_ready;
    assign alu_start = (state_q == EXEC);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        pend_d     = pend_q;
        chain_d    = chain_q;
        disp_err_d = disp_err_q;
        disp_val_d = disp_val_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        a_clr      = 1'b0;
        a_load     = 1'b0;
        a_load_val = alu_result;
        a_load_cnt = CW'(NDIG);
        a_shift    = 1'b0;
        b_clr      = 1'b0;
        b_shift    = 1'b0;

        case (state_q)
            ENTER_A: if (key_acc) begin
                if (is_digit(key_code)) begin
                    a_shift = 1'b1;
                end else if (is_op(key_code)) begin
                    op_d    = key_to_op(key_code);
                    b_clr   = 1'b1;
                    state_d = ENTER_B;
                end
            end
            ENTER_B: if (key_acc) begin
                if (is_digit(key_code)) begin
                    b_shift = 1'b1;
                end else if (is_op(key_code)) begin
                    if (b_cnt == '0) begin
                        op_d = key_to_op(key_code);
                    end else begin
                        chain_d = 1'b1;
                        pend_d  = key_to_op(key_code);
                        state_d = EXEC;
                    end
                end else if (key_code == KEY_EQ) begin
                    state_d = EXEC;
                end
            end
            EXEC: state_d = WAIT;
            WAIT: if (alu_done) begin
                if (alu_err) begin
                    disp_err_d = 1'b1;
                    state_d    = ERR;
                end else begin
                    a_load = 1'b1;
                    if (chain_q) begin
                        op_d    = pend_q;
                        b_clr   = 1'b1;
                        chain_d = 1'b0;
                        state_d = ENTER_B;
                    end else begin
                        state_d = SHOW;
                    end
                end
            end else if (to_hit) begin
                disp_err_d = 1'b1;
                state_d    = ERR;
            end
            SHOW: if (key_acc) begin
                if (is_digit(key_code)) begin
                    a_load     = 1'b1;
                    a_load_val = W'(key_code);
                    a_load_cnt = CW'(1);
                    state_d    = ENTER_A;
                end else if (is_op(key_code)) begin
                    op_d    = key_to_op(key_code);
                    b_clr   = 1'b1;
                    state_d = ENTER_B;
                end else if (key_code == KEY_EQ) begin
                    state_d = EXEC;
                end
            end
            ERR: ;
            default: state_d = ENTER_A;
        endcase

        if (key_acc && (key_code == KEY_CLR)) begin
            a_clr      = 1'b1;
            b_clr      = 1'b1;
            op_d       = OP_ADD;
            pend_d     = OP_ADD;
            chain_d    = 1'b0;
            disp_err_d = 1'b0;
            state_d    = ENTER_A;
        end

        // Display tracks the operand being edited; SHOW/ERR/busy states hold.
        if (state_q == WAIT && state_d == SHOW) begin
            disp_val_d = alu_result;
        end else if (state_d == ENTER_A) begin
            disp_val_d = a_nxt;
        end else if (state_d == ENTER_B) begin
            disp_val_d = (b_cnt_nxt != '0) ? b_nxt : a_nxt;
        end

        if (state_d == EXEC && state_q != EXEC) begin
            alu_a_d  = a_acc;
            alu_b_d  = b_acc;
            alu_op_d = op_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ENTER_A;
            op_q       <= OP_ADD;
            pend_q     <= OP_ADD;
            chain_q    <= 1'b0;
            disp_err_q <= 1'b0;
            disp_val_q <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= OP_ADD;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            pend_q     <= pend_d;
            chain_q    <= chain_d;
            disp_err_q <= disp_err_d;
            disp_val_q <= disp_val_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
        end
    end

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_op   = alu_op_q;
    assign disp_val = disp_val_q;
    assign disp_err = disp_err_q;

endmodule

// File: doc/calc_seq_ctrl.md
Name: calc_seq_ctrl

Overview:
Keypad-to-ALU sequencer for the FPGA calculator. It accepts decoded key codes and builds two decimal operands in binary accumulators. It latches the operator, launches the shared ALU with a start/done handshake, and holds the value or error flag for the display driver. It sits between the keypad decoder and the ALU/display datapath, all in the single `clk` domain.

Parameters:
W, 16, operand/result width in bits (unsigned).
NDIG, 4, maximum decimal digits accepted per operand.
TO_CYCLES, 1024, ALU watchdog limit (used only with the optional feature).

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous, active-low reset
key_valid  in  1  key_code holds a new key
key_code  in  4  0-9 digit, A add, B sub, C mul, D div, E equals, F clear
key_ready  out  1  controller can accept a key
alu_start  out  1  one-cycle launch pulse
alu_op  out  2  00 add, 01 sub, 10 mul, 11 div
alu_a  out  W  operand A
alu_b  out  W  operand B
alu_done  in  1  result valid, one-cycle pulse
alu_result  in  W  ALU result
alu_err  in  1  qualifies alu_done: overflow or divide-by-zero
disp_val  out  W  value to display
disp_err  out  1  display "Err"
busy  out  1  high in EXEC/WAIT

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is synchronous and active-low. Reset drives every output, accumulator, digit count and latched op to 0, with state ENTER_A. Exception: key_ready resets to 1.
- Key handshake: a key is accepted on a cycle with key_valid && key_ready. key_ready = !busy. Keys are never queued.
- Digit accumulation: acc <= acc*10 + d, truncated to W bits. Digits beyond NDIG in one operand are accepted and discarded.
- States:
  - ENTER_A: digit goes to A. Operator latches op, clears B and cntB, then goes to ENTER_B. Equals is ignored.
  - ENTER_B: digit goes to B. Operator with cntB==0 replaces op. Operator with cntB>0 sets the chain flag, stores the new op as pending, and goes to EXEC. Equals goes to EXEC.
  - EXEC: alu_start=1 for exactly one cycle, alu_a/alu_b/alu_op stable, then WAIT. alu_a/alu_b/alu_op hold until the next EXEC.
  - WAIT: on alu_done with alu_err=1, go to ERR and set disp_err=1. On alu_done with alu_err=0, A<=alu_result and disp_val<=alu_result. If chain is set: op<=pending, clear B and cntB, clear chain, go to ENTER_B. Otherwise go to SHOW.
  - SHOW: digit starts a fresh A (A=d, cntA=1), then ENTER_A. Operator uses the result as A and goes to ENTER_B. Equals repeats the last op with the same B and goes to EXEC.
  - ERR: only Clear has effect; other accepted keys are discarded.
- Clear (F) in any non-busy state: A, B, counts, op, chain and disp_err go to 0, state goes to ENTER_A, disp_val=0.
- disp_val is registered, updated the cycle after acceptance. ENTER_A shows A. ENTER_B shows B if cntB>0, else A.
- alu_done outside WAIT is ignored. alu_done arriving in the same cycle as alu_start is illegal (minimum ALU latency 1).
- Reset mid-WAIT: state returns to ENTER_A and any later alu_done is ignored.
- Total latency: equals accepted at cycle N, then alu_start at N+1, then result visible on disp_val one cycle after alu_done.

Optional Feature:
CALC_SEQ_CTRL_TIMEOUT_EN: a counter runs in WAIT. If TO_CYCLES elapse without alu_done, go to ERR with disp_err=1; a late alu_done is ignored. Without the macro, WAIT is unbounded and no counter is synthesized.

Decomposition:
- Package calc_pkg holds: key code constants (KEY_ADD..KEY_CLR), ALU op encoding, the state enum (ENTER_A, ENTER_B, EXEC, WAIT, SHOW, ERR), and the NDIG/W defaults.
- Sub-module calc_dec_acc: digit accumulator with load/clear/shift-in-digit and saturating digit counter. Instantiated twice, for A and B.

Test Plan:
- Keys 1,2,A,3,4,E with the ALU model returning a+b after 3 cycles: alu_start pulses once with a=12, b=34, op=00; then disp_val=46, state SHOW.
- Keys 1,2,3,4,5 (NDIG=4): disp_val=1234; the fifth digit is discarded.
- Keys 9,D,0,E with the model asserting alu_err: disp_err=1. Keys 5,A are then ignored. Key F gives disp_err=0, disp_val=0, state ENTER_A.
- Chain 2,A,3,C,4,E: first start a=2,b=3,op=00, then a=5,b=4,op=10, then disp_val=20. key_ready=0 throughout both WAIT periods.
- SHOW repeat: after 2,A,3,E (result 5), pressing E again launches a=5,b=3 and gives disp_val=8.
- rst_n low during WAIT, then a stray alu_done: all outputs 0, state ENTER_A. With the timeout macro and no alu_done, ERR is reached after 1024 cycles.
